// File: rtl/sort_drain.sv
// Drains the sorted array from the shared sort memory as a valid/ready stream
// with last/index sideband and a sticky in-line monotonicity check.
module sort_drain #(
  parameter int MM = 256,
  parameter int MN = 32,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [MW:0]   num,
  input  logic          done_in,
  output logic          busy,
  output logic          finished,
  output logic          order_err,
  output logic          MemRd,
  output logic [MW-1:0] MemRdAddr,
  input  logic [MN-1:0] MemRdData,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MN-1:0] out_data,
  output logic          out_last,
  output logic [MW-1:0] out_index
);

  localparam logic [MW:0] MM_W  = (MW+1)'(MM);
  localparam logic [MW:0] ONE_W = {{MW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [MW:0]   n_r;
  logic [MW:0]   rd_cnt_r;
  logic [MW:0]   idx_r;
  logic          inflight_r;
  logic [MN-1:0] fifo0_r;
  logic [MN-1:0] fifo1_r;
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    cnt_r;
  logic [MN-1:0] prev_r;
  logic          err_r;

  logic          done_acc_s;
  logic [MW:0]   num_clip_s;
  logic [MW:0]   n_last_s;
  logic [2:0]    occ_s;
  logic          mem_rd_s;
  logic          valid_s;
  logic [MN-1:0] head_s;
  logic          xfer_s;
  logic          store_s;
  logic          pop_s;
  logic          last_beat_s;

  assign done_acc_s  = done_in && (state_r == IDLE);
  assign num_clip_s  = (num > MM_W) ? MM_W : num;
  assign n_last_s    = n_r - ONE_W;
  assign occ_s       = {1'b0, cnt_r} + {2'b00, inflight_r};
  assign mem_rd_s    = (state_r == READ) && (occ_s < 3'd2);

  // A word arriving this cycle is presented directly when nothing is stored,
  // which gives the one-cycle MemRd-to-valid latency and bubble-free streaming.
  assign valid_s     = (cnt_r != 2'd0) || inflight_r;
  assign xfer_s      = valid_s && out_ready;
  assign store_s     = inflight_r && !((cnt_r == 2'd0) && xfer_s);
  assign pop_s       = xfer_s && (cnt_r != 2'd0);
  assign last_beat_s = xfer_s && (idx_r == n_last_s);

  // FIFO head selection: stored entry first, otherwise the arriving read word.
  always_comb begin
    head_s = MemRdData;
    if (cnt_r != 2'd0) begin
      head_s = rd_ptr_r ? fifo1_r : fifo0_r;
    end else begin
      head_s = MemRdData;
    end
  end

  // Next-state logic for the drain sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (done_in) begin
          state_next_s = (num_clip_s != {(MW+1){1'b0}}) ? READ : FINISH;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (mem_rd_s && (rd_cnt_r == n_last_s)) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = READ;
        end
      end
      DRAIN: begin
        if (last_beat_s) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = DRAIN;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Count latch, read address counter, beat index and read-in-flight flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_r        <= {(MW+1){1'b0}};
      rd_cnt_r   <= {(MW+1){1'b0}};
      idx_r      <= {(MW+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= mem_rd_s;
      if (done_acc_s) begin
        n_r      <= num_clip_s;
        rd_cnt_r <= {(MW+1){1'b0}};
      end else if (mem_rd_s) begin
        rd_cnt_r <= rd_cnt_r + ONE_W;
      end
      if (done_acc_s || (state_r == FINISH)) begin
        idx_r <= {(MW+1){1'b0}};
      end else if (xfer_s) begin
        idx_r <= idx_r + ONE_W;
      end
    end
  end

  // Two-entry FIFO; a push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo0_r  <= {MN{1'b0}};
      fifo1_r  <= {MN{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (store_s) begin
        if (wr_ptr_r) begin
          fifo1_r <= MemRdData;
        end else begin
          fifo0_r <= MemRdData;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r <= cnt_r + {1'b0, store_s} - {1'b0, pop_s};
    end
  end

  // Monotonicity check against the previously accepted word; sticky per drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= {MN{1'b0}};
      err_r  <= 1'b0;
    end else begin
      if (xfer_s) begin
        prev_r <= head_s;
      end
      if (done_acc_s) begin
        err_r <= 1'b0;
      end else if (xfer_s && (idx_r != {(MW+1){1'b0}}) && (head_s < prev_r)) begin
        err_r <= 1'b1;
      end
    end
  end

  assign busy      = (state_r != IDLE);
  assign finished  = (state_r == FINISH);
  assign order_err = err_r;
  assign MemRd     = mem_rd_s;
  assign MemRdAddr = mem_rd_s ? rd_cnt_r[MW-1:0] : {MW{1'b0}};
  assign out_valid = valid_s;
  assign out_data  = valid_s ? head_s : {MN{1'b0}};
  assign out_last  = valid_s && (idx_r == n_last_s);
  assign out_index = idx_r[MW-1:0];

endmodule

// File: tb/tb_sort_drain.sv
// Randomized scoreboard bench for sort_drain: stimulus pushes the expected beats,
// a negedge monitor pops and compares whenever a beat is accepted.
module tb_sort_drain;
  localparam int MM = 256;
  localparam int MN = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [MW:0]   num = '0;
  logic          done_in = 1'b0;
  logic          busy, finished, order_err, MemRd;
  logic [MW-1:0] MemRdAddr;
  logic [MN-1:0] MemRdData = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MN-1:0] out_data;
  logic          out_last;
  logic [MW-1:0] out_index;

  sort_drain #(.MM(MM), .MN(MN), .MW(MW)) dut (
    .clk(clk), .reset_n(reset_n), .num(num), .done_in(done_in),
    .busy(busy), .finished(finished), .order_err(order_err),
    .MemRd(MemRd), .MemRdAddr(MemRdAddr), .MemRdData(MemRdData),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_index(out_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MN-1:0] d;
    int            idx;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [MN-1:0] mem [MM];
  int            cyc = 0;
  int            pass_cnt = 0, tot_cnt = 0;
  int            rd_addr_m, reads, beats, fins, busy_cyc, valid_cyc;
  int            t_done, t_rd, t_val, t_fin;
  logic          err_m = 1'b0;
  logic [MN-1:0] prev_m = '0;
  logic          stall_p = 1'b0;
  logic [MN-1:0] stall_d;
  int            stall_i;
  logic          done_accept = 1'b0;
  int            ready_mode = 0;
  int            rcnt = 0;
  logic          rd_q = 1'b0;
  logic [MW-1:0] a_q = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Memory: data for a read strobe appears the next cycle only; garbage otherwise.
  always @(negedge clk) begin
    rd_q = MemRd;
    a_q  = MemRdAddr;
  end
  always @(posedge clk) begin
    #1;
    MemRdData = rd_q ? mem[a_q] : $urandom;
    rcnt++;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rcnt % 3) == 0);
      default: out_ready = $urandom_range(0, 1);
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_p = 1'b0;
    end else begin
      beat_t b;
      chk("order_err", order_err, err_m);
      if (busy) busy_cyc++;
      if (out_valid) begin
        valid_cyc++;
        if (valid_cyc == 1) t_val = cyc;
      end
      if (finished) begin
        fins++;
        t_fin = cyc;
      end
      if (MemRd) begin
        chk("rd_addr", MemRdAddr, rd_addr_m);
        if (reads == 0) t_rd = cyc;
        reads++;
        rd_addr_m++;
        chk("outstanding_le2", ((reads - beats) <= 2), 1);
      end
      if (stall_p) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, stall_d);
        chk("stall_index", out_index, stall_i);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_index", out_index, b.idx);
          chk("beat_last", out_last, b.last);
          if (b.idx > 0 && b.d < prev_m) err_m = 1'b1;
          prev_m = b.d;
        end
        beats++;
      end else if (out_valid && exp_q.size() != 0) begin
        chk("stalled_last", out_last, exp_q[0].last);
      end
      stall_p = out_valid && !out_ready;
      stall_d = out_data;
      stall_i = out_index;
      if (done_in && done_accept) begin
        err_m  = 1'b0;
        t_done = cyc;
      end
    end
  end

  function automatic int clip(input int n);
    return (n > MM) ? MM : n;
  endfunction

  task automatic start_drain(input int n);
    int nc;
    nc = clip(n);
    for (int i = 0; i < nc; i++) begin
      beat_t b;
      b.d = mem[i];
      b.idx = i;
      b.last = (i == nc - 1);
      exp_q.push_back(b);
    end
    reads = 0; beats = 0; fins = 0; busy_cyc = 0; valid_cyc = 0; rd_addr_m = 0;
    t_done = -100; t_rd = -100; t_val = -100; t_fin = -100;
    @(posedge clk); #1;
    num = n[MW:0];
    done_in = 1'b1;
    done_accept = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    done_accept = 1'b0;
  endtask

  task automatic wait_finish(input int n, input string nm);
    int nc, k;
    nc = clip(n);
    k = 0;
    while (fins == 0 && k < nc * 8 + 40) begin
      @(posedge clk);
      k++;
    end
    if (fins == 0) chk({nm, "_finish_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_beats"}, beats, nc);
    chk({nm, "_reads"}, reads, nc);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_finished_once"}, fins, 1);
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic check_timing(input int n, input string nm);
    chk({nm, "_fin_lat"}, t_fin - t_done, clip(n) + 2);
    if (clip(n) > 0) begin
      chk({nm, "_rd_lat"}, t_rd - t_done, 1);
      chk({nm, "_val_lat"}, t_val - t_done, 2);
    end
  endtask

  initial begin
    int n, acc;
    #2;
    chk("reset_outputs", {busy, finished, order_err, MemRd, MemRdAddr, out_valid,
                          out_data, out_last, out_index}, 0);
    for (int i = 0; i < MM; i++) mem[i] = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic drain, out_ready held high.
    mem[0] = 32'd3; mem[1] = 32'd7; mem[2] = 32'd7; mem[3] = 32'd42;
    ready_mode = 0;
    start_drain(4);
    wait_finish(4, "basic");
    check_timing(4, "basic");
    chk("basic_no_err", order_err, 0);

    // Same data with a stalling consumer.
    ready_mode = 1;
    start_drain(4);
    wait_finish(4, "stall");

    // Empty drain.
    ready_mode = 0;
    start_drain(0);
    wait_finish(0, "empty");
    chk("empty_busy_cycles", busy_cyc, 1);
    chk("empty_no_valid", valid_cyc, 0);

    // Order error, sticky past finished, cleared by the next done_in.
    mem[0] = 32'd5; mem[1] = 32'd9; mem[2] = 32'd4;
    start_drain(3);
    wait_finish(3, "order");
    chk("order_err_sticky", order_err, 1);
    mem[0] = 32'd1; mem[1] = 32'd2;
    start_drain(2);
    chk("order_err_cleared", order_err, 0);
    wait_finish(2, "clean");

    // Single element, with a second done_in while busy.
    mem[0] = 32'hdead_beef;
    start_drain(1);
    num = 9'd5;
    done_in = 1'b1;
    @(posedge clk); #1;
    done_in = 1'b0;
    wait_finish(1, "single");

    // Reset in the middle of a drain, then a fresh full drain.
    for (int i = 0; i < 8; i++) mem[i] = 32'(i * 10 + 1);
    start_drain(8);
    acc = 0;
    while (beats < 2 && acc < 50) begin
      @(posedge clk);
      acc++;
    end
    chk("reset_reached_2_beats", (beats >= 2), 1);
    #2 reset_n = 1'b0;
    #1 chk("midreset_outputs", {busy, finished, order_err, MemRd, MemRdAddr, out_valid,
                                out_data, out_last, out_index}, 0);
    exp_q.delete();
    err_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_no_finished", fins, 0);
    start_drain(8);
    wait_finish(8, "after_reset");
    check_timing(8, "after_reset");

    // Randomized drains, including count clipping to the memory depth.
    for (int it = 0; it < 8; it++) begin
      logic [MN-1:0] acc_v;
      logic          sorted;
      n = $urandom_range(0, 40);
      if (it == 2) n = 300;
      if (it == 5) n = 256;
      ready_mode = $urandom_range(0, 2);
      sorted = $urandom_range(0, 1);
      acc_v = $urandom_range(0, 100);
      for (int i = 0; i < MM; i++) begin
        acc_v = acc_v + 32'($urandom_range(0, 3));
        mem[i] = sorted ? acc_v : $urandom;
      end
      start_drain(n);
      wait_finish(n, "random");
      if (ready_mode == 0) check_timing(n, "random");
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
